d_line_burst_adapter: RTL and testbench
=======================================

// Module: d_line_burst_adapter
// PURPOSE
// - Downstream neighbour of the D-side stride prefetcher: converts single 256-bit line read/write requests into
//   64-bit burst transactions on the memory (bmem) port, and reassembles read bursts into one line response.
// - Strictly one transaction in flight. Each response carries the address of the line it belongs to.
// PARAMETERS
// - LINE_W  256  line width in bits, same as the prefetcher data path
// - BEAT_W  64   bmem beat width; BEATS = LINE_W/BEAT_W = 4, beat i maps to line bits [BEAT_W*i +: BEAT_W]
// PORTS
// - clk          in   1    clock
// - rst          in   1    reset: synchronous, active-high
// - line_addr    in   32   request address from the prefetcher; the adapter zeroes bits [4:0]
// - line_read    in   1    read-line request; level, held until line_resp
// - line_write   in   1    write-line request; level, held until line_resp
// - line_wdata   in   256  write line data
// - line_rdata   out  256  assembled read line; valid with line_resp
// - line_resp    out  1    one-cycle completion pulse, for reads and writes
// - line_raddr   out  32   line-aligned address of the completing transaction; valid with line_resp
// - bmem_addr    out  32   burst address, line-aligned
// - bmem_read    out  1    read command, one cycle
// - bmem_write   out  1    write beat valid
// - bmem_wdata   out  64   write beat data
// - bmem_ready   in   1    memory accepts the command or beat this cycle
// - bmem_raddr   in   32   address tag of the returning read beat
// - bmem_rdata   in   64   read beat data
// - bmem_rvalid  in   1    read beat valid
// BEHAVIOUR
// - Reset values: line_resp=0, line_rdata=0, line_raddr=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
//   Reset clears the beat counter and the latched request, and the state machine goes to IDLE.
// - Reset mid-burst drops the transaction; beats still arriving afterwards are ignored because the state is IDLE.
// - There is no flush input. Any accepted transaction always runs to completion.
//   After an upstream flush, the prefetcher discards the stale response using the line_raddr tag.
// - States: IDLE, RD_CMD, RD_DATA, WR_DATA, RESP.
// - IDLE: a request is accepted only in this state.
//   - Latch {line_addr[31:5],5'b0}, line_wdata and the request kind.
//   - line_read -> RD_CMD. line_write -> WR_DATA.
//   - Both asserted is illegal; write wins and an assertion fires.
// - RD_CMD: bmem_read=1 with bmem_addr held. Leaves for RD_DATA on the first cycle with bmem_ready=1.
// - RD_DATA: a beat is captured when bmem_rvalid=1 and bmem_raddr[31:5] matches the latched line.
//   - A captured beat goes to buffer slot cnt, then cnt++. Non-matching beats are ignored.
//   - The cycle the last (4th) beat is captured -> RESP.
// - WR_DATA: bmem_write=1, bmem_addr held, bmem_wdata = latched beat cnt.
//   - cnt advances only when bmem_ready=1, so a low ready holds the beat stable.
//   - The 4th accepted beat -> RESP.
// - RESP: line_resp=1 for exactly one cycle.
//   - line_raddr = latched line address; line_rdata = buffer (reads) or 0 (writes). Next state is IDLE.
//   - Request inputs seen during RESP are not accepted; this avoids re-taking the held request.
// - Latency with ideal memory (ready=1, first beat returning N cycles after the command):
//   - read: request to line_resp = N+5 cycles.
//   - write: request to line_resp = 6 cycles.
// - Back-to-back: a request presented in the cycle after RESP is accepted in that cycle.
// - The 2-bit cnt is cleared on entry to RD_DATA and WR_DATA. No wrap beyond 4 beats is possible.
// STRUCTURE
// - Shared package d_mem_pkg: the state enum, the LINE_W/BEAT_W/BEATS constants, and line_offset(addr)=addr[4:0].
// - One natural sub-module, line_beat_buf: a 4x64 register file with beat-indexed write, 256-bit flat read,
//   and a 256-bit parallel load used for write data.
// TESTING
// - Read 0x0000_1040, bmem returns beats A,B,C,D -> one line_resp, line_rdata={D,C,B,A}, line_raddr=0x0000_1040.
// - Read at unaligned 0x0000_104C -> bmem_addr=0x0000_1040 and line_raddr=0x0000_1040.
// - Write 0x0000_2000 with bmem_ready low on beat 2 for 3 cycles -> beat 2 held stable, 4 beats total, line_resp once.
// - A stray rvalid beat with raddr 0x0000_3000 during a read of 0x0000_1040 -> ignored, and the assembled line is
//   unchanged.
// - rst asserted after 2 read beats, then 2 late beats arrive -> no line_resp. A following read completes correctly.
// - line_read held through RESP, then dropped -> exactly one bmem_read is issued, with no duplicate transaction.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared definitions for the D-side memory path.
// Provides the adapter state encoding, the line/beat geometry constants and
// the line_offset helper, which returns the byte offset of an address within
// its 32-byte line.
package d_mem_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA,
        RESP
    } state_t;

    function automatic logic [4:0] line_offset(input logic [31:0] addr);
        return 5'(addr % 32);
    endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Line buffer: BEATS x BEAT_W register file.
// Ports:
//   clk        clock
//   wr_en      write one beat at slot wr_idx (read reassembly)
//   wr_idx     beat slot
//   wr_beat    beat data
//   load       parallel load of a whole line (write data); wins over wr_en
//   load_line  line to load
//   line       flat view, slot i at bits [BEAT_W*i +: BEAT_W]
module line_beat_buf
    import d_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [CNT_W-1:0]     wr_idx,
    input  logic [BEAT_W-1:0]    wr_beat,
    input  logic                 load,
    input  logic [LINE_W-1:0]    load_line,
    output logic [LINE_W-1:0]    line
);

    logic [BEAT_W-1:0] mem [BEATS];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < BEATS; i++) begin
                mem[i] <= load_line[BEAT_W*i +: BEAT_W];
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_beat;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < BEATS; i++) begin
            line[BEAT_W*i +: BEAT_W] = mem[i];
        end
    end

endmodule

// File: rtl/d_line_burst_adapter.sv
// Line-to-burst adapter between the D-side stride prefetcher and bmem.
// Converts one 256-bit line read/write into 4 x 64-bit bmem beats and
// reassembles read bursts into a single line response. One transaction in
// flight; every response is tagged with its line-aligned address.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   line_addr/read/write/wdata    line request (level, held until line_resp)
//   line_rdata/resp/raddr         one-cycle completion with data and tag
//   bmem_addr/read/write/wdata    burst command and write beats
//   bmem_ready                    memory accepts command/beat this cycle
//   bmem_raddr/rdata/rvalid       returning read beats with address tag
module d_line_burst_adapter
    import d_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          line_addr,
    input  logic                 line_read,
    input  logic                 line_write,
    input  logic [LINE_W-1:0]    line_wdata,
    output logic [LINE_W-1:0]    line_rdata,
    output logic                 line_resp,
    output logic [31:0]          line_raddr,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_W-1:0]    bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_W-1:0]    bmem_rdata,
    input  logic                 bmem_rvalid
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        lat_addr;

    logic [31:0]        req_line;
    logic               beat_hit;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   wr_idx;
    logic [BEAT_W-1:0]  wr_beat;
    logic [LINE_W-1:0]  buf_line;

    assign req_line = line_addr - 32'(line_offset(line_addr));
    // Beats are matched on the line part of their tag only.
    assign beat_hit = bmem_rvalid &&
                      ((bmem_raddr - 32'(line_offset(bmem_raddr))) == lat_addr);
    assign cnt_nxt  = cnt + 1'b1;
    // bmem_write low inside WR_DATA marks the setup cycle after the buffer
    // load; beat 0 is fetched then, later beats look one slot ahead.
    assign wr_idx   = bmem_write ? cnt_nxt : cnt;
    assign wr_beat  = buf_line[BEAT_W*wr_idx +: BEAT_W];

    line_beat_buf u_buf (
        .clk       (clk),
        .wr_en     (state == RD_DATA && beat_hit),
        .wr_idx    (cnt),
        .wr_beat   (bmem_rdata),
        .load      (state == IDLE && line_write),
        .load_line (line_wdata),
        .line      (buf_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            line_resp  <= 1'b0;
            line_rdata <= '0;
            line_raddr <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= '0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write) begin
                        lat_addr  <= req_line;
                        bmem_addr <= req_line;
                        cnt       <= '0;
                        state     <= WR_DATA;
                    end else if (line_read) begin
                        lat_addr  <= req_line;
                        bmem_addr <= req_line;
                        bmem_read <= 1'b1;
                        state     <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        cnt       <= '0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (beat_hit) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST_BEAT) begin
                            // The last beat lands in the buffer on this same
                            // edge, so splice it in directly.
                            line_rdata <= {bmem_rdata, buf_line[LINE_W-BEAT_W-1:0]};
                            line_raddr <= lat_addr;
                            line_resp  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                WR_DATA: begin
                    if (!bmem_write) begin
                        bmem_write <= 1'b1;
                        bmem_wdata <= wr_beat;
                    end else if (bmem_ready) begin
                        if (cnt == LAST_BEAT) begin
                            bmem_write <= 1'b0;
                            line_rdata <= '0;
                            line_raddr <= lat_addr;
                            line_resp  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            cnt        <= cnt_nxt;
                            bmem_wdata <= wr_beat;
                        end
                    end
                end
                RESP: begin
                    // Requests still held here belong to this transaction.
                    line_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_single_request: assert property (@(posedge clk) disable iff (rst)
        !(state == IDLE && line_read && line_write));

endmodule

// File: tb/tb_d_line_burst_adapter.sv
module tb_d_line_burst_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  line_addr;
    logic         line_read;
    logic         line_write;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic [31:0]  line_raddr;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int checks   = 0;
    int failures = 0;
    int n_cmd    = 0;
    int n_resp   = 0;
    int exp_cmd  = 0;
    int exp_resp = 0;

    logic [63:0] rbeat [4];

    d_line_burst_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .line_addr   (line_addr),
        .line_read   (line_read),
        .line_write  (line_write),
        .line_wdata  (line_wdata),
        .line_rdata  (line_rdata),
        .line_resp   (line_resp),
        .line_raddr  (line_raddr),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bmem_read) n_cmd++;
        if (line_resp) n_resp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Read with first beat 'lat' cycles after the command; stray_at in 0..3
    // inserts a foreign-tagged beat before that beat, other values mean none.
    task automatic do_read(input logic [31:0] addr, input int lat,
                           input int stray_at, input logic [31:0] stray_addr);
        logic [31:0]  al;
        logic [255:0] exp;
        al = addr & 32'hFFFF_FFE0;
        for (int i = 0; i < 4; i++) exp[64*i +: 64] = rbeat[i];
        line_addr  = addr;
        line_read  = 1'b1;
        line_write = 1'b0;
        bmem_ready = 1'b1;
        step();
        exp_cmd++;
        check("rd_cmd", 256'(bmem_read), 256'(1'b1));
        check("rd_bmem_addr", 256'(bmem_addr), 256'(al));
        repeat (lat) step();
        for (int k = 0; k < 4; k++) begin
            if (k == stray_at) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = stray_addr;
                bmem_rdata  = 64'({$urandom(), $urandom()});
                step();
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = al | 32'($urandom_range(0, 31));
            bmem_rdata  = rbeat[k];
            if (k == 3) check("rd_no_early_resp", 256'(line_resp), 256'(1'b0));
            step();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        exp_resp++;
        check("rd_resp", 256'(line_resp), 256'(1'b1));
        check("rd_rdata", line_rdata, exp);
        check("rd_raddr", 256'(line_raddr), 256'(al));
        line_read = 1'b0;
        step();
        check("rd_resp_one_cycle", 256'(line_resp), 256'(1'b0));
        check("rd_no_reissue", 256'(bmem_read), 256'(1'b0));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                            input int stall_beat, input int stall_len);
        logic [31:0] al;
        int acc;
        int stalled;
        int cyc;
        bit done;
        al = addr & 32'hFFFF_FFE0;
        acc = 0; stalled = 0; cyc = 0; done = 1'b0;
        line_addr  = addr;
        line_wdata = data;
        line_write = 1'b1;
        line_read  = 1'b0;
        bmem_ready = 1'b1;
        while (!done && cyc < 40) begin
            step();
            cyc++;
            line_wdata = rand_line();
            if (line_resp) begin
                done = 1'b1;
            end else if (bmem_write) begin
                check("wr_bmem_addr", 256'(bmem_addr), 256'(al));
                if (acc < 4) check("wr_beat_data", 256'(bmem_wdata), 256'(data[64*acc +: 64]));
                if (acc == stall_beat && stalled < stall_len) begin
                    bmem_ready = 1'b0;
                    stalled++;
                end else begin
                    bmem_ready = 1'b1;
                    acc++;
                end
            end else begin
                bmem_ready = 1'b1;
            end
        end
        exp_resp++;
        check("wr_beats", 256'(acc), 256'(4));
        check("wr_latency", 256'(cyc), 256'(6 + stall_len));
        check("wr_raddr", 256'(line_raddr), 256'(al));
        check("wr_rdata_zero", line_rdata, 256'(0));
        line_write = 1'b0;
        bmem_ready = 1'b1;
        step();
        check("wr_resp_one_cycle", 256'(line_resp), 256'(1'b0));
        check("wr_idle", 256'(bmem_write), 256'(1'b0));
    endtask

    initial begin
        rst         = 1'b1;
        line_addr   = '0;
        line_read   = 1'b0;
        line_write  = 1'b0;
        line_wdata  = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        step();
        step();
        check("rst_line_resp", 256'(line_resp), 256'(0));
        check("rst_line_rdata", line_rdata, 256'(0));
        check("rst_line_raddr", 256'(line_raddr), 256'(0));
        check("rst_bmem_read", 256'(bmem_read), 256'(0));
        check("rst_bmem_write", 256'(bmem_write), 256'(0));
        check("rst_bmem_addr", 256'(bmem_addr), 256'(0));
        check("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
        rst = 1'b0;
        step();

        // Plain read, beats A..D.
        rbeat[0] = 64'hAAAA_0000_0000_000A;
        rbeat[1] = 64'hBBBB_0000_0000_000B;
        rbeat[2] = 64'hCCCC_0000_0000_000C;
        rbeat[3] = 64'hDDDD_0000_0000_000D;
        do_read(32'h0000_1040, 1, -1, 32'h0);

        // Unaligned request address.
        for (int i = 0; i < 4; i++) rbeat[i] = 64'({$urandom(), $urandom()});
        do_read(32'h0000_104C, 2, -1, 32'h0);

        // Write with beat 2 stalled for 3 cycles, issued back-to-back.
        do_write(32'h0000_2000, rand_line(), 2, 3);

        // Stray beat tagged 0x3000 in the middle of a read of 0x1040.
        for (int i = 0; i < 4; i++) rbeat[i] = 64'({$urandom(), $urandom()});
        do_read(32'h0000_1040, 1, 2, 32'h0000_3000);

        // Reset after two read beats, then two late beats arrive.
        line_addr  = 32'h0000_1040;
        line_read  = 1'b1;
        step();
        exp_cmd++;
        step();
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_1040;
            bmem_rdata  = 64'({$urandom(), $urandom()});
            step();
        end
        bmem_rvalid = 1'b0;
        line_read   = 1'b0;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_bmem_read", 256'(bmem_read), 256'(0));
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_1040;
            bmem_rdata  = 64'({$urandom(), $urandom()});
            step();
        end
        bmem_rvalid = 1'b0;
        step();
        check("midrst_no_resp", 256'(n_resp), 256'(exp_resp));
        check("midrst_line_resp", 256'(line_resp), 256'(0));
        for (int i = 0; i < 4; i++) rbeat[i] = 64'({$urandom(), $urandom()});
        do_read(32'h0000_1040, 3, -1, 32'h0);

        // Randomized mix against the line/beat model.
        for (int t = 0; t < 10; t++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, rand_line(), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                for (int i = 0; i < 4; i++) rbeat[i] = 64'({$urandom(), $urandom()});
                do_read(a, $urandom_range(1, 4), $urandom_range(0, 4),
                        (a & 32'hFFFF_FFE0) ^ (32'h20 << $urandom_range(0, 26)));
            end
        end

        step();
        check("total_bmem_read_cycles", 256'(n_cmd), 256'(exp_cmd));
        check("total_line_resp", 256'(n_resp), 256'(exp_resp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
